watch_key_fsm: RTL and testbench

Stopwatch key-interpretation stage. Sits between the per-key debounce filters and the 10 ms counter/display controller. Turns three debounced, active-low button levels into one-shot press events. A 4-state FSM then drives count enable, display hold and a count-clear pulse for the downstream counter.

---
 rtl/watch_key_fsm.sv | 119 +++++++++++
 tb/tb_watch_key_fsm.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/watch_key_fsm.sv
// rtl/watch_key_fsm.sv - stopwatch key interpreter: press detection and run/pause/freeze FSM
// Optional long-press clear is selected with `define LONG_PRESS_CLEAR_EN.
module watch_key_fsm #(
   parameter int LONG_PRESS_CYCLES = 100000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_start_pause_n,
   input  logic       key_display_n,
   input  logic       key_clear_n,
   output logic       count_en,
   output logic       display_hold,
   output logic       clear_pulse,
   output logic [1:0] state,
   output logic       event_pulse
);

   localparam int CNT_W = $clog2(LONG_PRESS_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      RUN    = 2'b01,
      PAUSE  = 2'b10,
      FREEZE = 2'b11
   } state_t;

   state_t cur_state;
   state_t nxt_state;
   logic   prev_start;
   logic   prev_display;
   logic   press_start;
   logic   press_display;
   logic   clear_evt;
   logic   accepted;

   // Previous samples reset to "pressed" so a key held through reset cannot fire.
   assign press_start   = prev_start & ~key_start_pause_n;
   assign press_display = prev_display & ~key_display_n;

`ifdef LONG_PRESS_CLEAR_EN
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LONG_PRESS_CYCLES);

   logic [CNT_W-1:0] hold_cnt;
   logic             clear_armed;

   // Counting only starts once the key has been seen released after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_cnt    <= '0;
         clear_armed <= 1'b0;
      end else if (key_clear_n) begin
         hold_cnt    <= '0;
         clear_armed <= 1'b1;
      end else if (clear_armed && hold_cnt != CNT_MAX) begin
         hold_cnt <= hold_cnt + CNT_W'(1);
      end
   end

   assign clear_evt = ~key_clear_n & clear_armed & (hold_cnt == CNT_MAX - CNT_W'(1));
`else
   logic prev_clear;
   logic unused_cfg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) prev_clear <= 1'b0;
      else       prev_clear <= key_clear_n;
   end

   assign clear_evt  = prev_clear & ~key_clear_n;
   assign unused_cfg = (CNT_W > 0);
`endif

   // Priority clear > start/pause > display; losers in the same cycle are dropped.
   always_comb begin
      nxt_state = cur_state;
      if (clear_evt) begin
         nxt_state = IDLE;
      end else if (press_start) begin
         case (cur_state)
            IDLE:    nxt_state = RUN;
            RUN:     nxt_state = PAUSE;
            PAUSE:   nxt_state = RUN;
            FREEZE:  nxt_state = PAUSE;
            default: nxt_state = IDLE;
         endcase
      end else if (press_display) begin
         case (cur_state)
            RUN:     nxt_state = FREEZE;
            FREEZE:  nxt_state = RUN;
            default: nxt_state = cur_state;
         endcase
      end
   end

   assign accepted = clear_evt | (nxt_state != cur_state);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cur_state    <= IDLE;
         prev_start   <= 1'b0;
         prev_display <= 1'b0;
         count_en     <= 1'b0;
         display_hold <= 1'b0;
         clear_pulse  <= 1'b0;
         event_pulse  <= 1'b0;
      end else begin
         cur_state    <= nxt_state;
         prev_start   <= key_start_pause_n;
         prev_display <= key_display_n;
         count_en     <= (nxt_state == RUN) || (nxt_state == FREEZE);
         display_hold <= (nxt_state == FREEZE);
         clear_pulse  <= clear_evt;
         event_pulse  <= accepted;
      end
   end

   assign state = cur_state;

endmodule

// File: tb/tb_watch_key_fsm.sv
// tb/tb_watch_key_fsm.sv - table-driven and sequence checks for watch_key_fsm
module tb_watch_key_fsm;

   logic       clk = 1'b0;
   logic       reset;
   logic       ks, kd, kc;
   logic       count_en, display_hold, clear_pulse, event_pulse;
   logic [1:0] state;

   int pass_cnt = 0;
   int total_cnt = 0;

`ifdef LONG_PRESS_CLEAR_EN
   localparam bit LP = 1'b1;
`else
   localparam bit LP = 1'b0;
`endif

   typedef struct {
      logic       s, d, c;
      logic [5:0] exp;
   } vec_t;

   vec_t vq[$];

   watch_key_fsm #(.LONG_PRESS_CYCLES(8)) dut (
      .clk               (clk),
      .reset             (reset),
      .key_start_pause_n (ks),
      .key_display_n     (kd),
      .key_clear_n       (kc),
      .count_en          (count_en),
      .display_hold      (display_hold),
      .clear_pulse       (clear_pulse),
      .state             (state),
      .event_pulse       (event_pulse)
   );

   always #5 clk = ~clk;

   function automatic logic [5:0] obs();
      return {state, count_en, display_hold, clear_pulse, event_pulse};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic add_v(input logic s, d, c, input logic [1:0] st,
                        input logic en, hd, cl, ev);
      vec_t v;
      v.s = s; v.d = d; v.c = c;
      v.exp = {st, en, hd, cl, ev};
      vq.push_back(v);
   endtask

   task automatic step(input logic s, d, c);
      @(negedge clk);
      ks = s; kd = d; kc = c;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic s, d, c);
      @(negedge clk);
      reset = 1'b1;
      ks = s; kd = d; kc = c;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   int n_evt;
   int first_idx;

   initial begin
      reset = 1'b1;
      ks = 1'b1; kd = 1'b1; kc = 1'b1;

      // state, en, hold, clr, evt per row
      add_v(1,1,1, 2'd0,0,0,0,0);
      add_v(0,1,1, 2'd1,1,0,0,1);
      add_v(0,1,1, 2'd1,1,0,0,0);
      add_v(1,1,1, 2'd1,1,0,0,0);
      add_v(1,0,1, 2'd3,1,1,0,1);
      add_v(1,1,1, 2'd3,1,1,0,0);
      add_v(1,0,1, 2'd1,1,0,0,1);
      add_v(1,1,1, 2'd1,1,0,0,0);
      add_v(1,0,1, 2'd3,1,1,0,1);
      add_v(1,1,1, 2'd3,1,1,0,0);
      add_v(0,1,1, 2'd2,0,0,0,1);
      add_v(1,1,1, 2'd2,0,0,0,0);
      add_v(1,0,1, 2'd2,0,0,0,0);
      add_v(1,1,1, 2'd2,0,0,0,0);
      add_v(0,1,1, 2'd1,1,0,0,1);
      add_v(1,1,1, 2'd1,1,0,0,0);
      if (LP) begin
         add_v(0,1,0, 2'd2,0,0,0,1);
         add_v(1,1,1, 2'd2,0,0,0,0);
      end else begin
         add_v(0,1,0, 2'd0,0,0,1,1);
         add_v(1,1,1, 2'd0,0,0,0,0);
      end
      add_v(0,0,1, 2'd1,1,0,0,1);
      add_v(1,1,1, 2'd1,1,0,0,0);
      if (LP) begin
         add_v(1,1,0, 2'd1,1,0,0,0);
         add_v(1,1,1, 2'd1,1,0,0,0);
         add_v(1,1,0, 2'd1,1,0,0,0);
         add_v(1,1,1, 2'd1,1,0,0,0);
      end else begin
         add_v(1,1,0, 2'd0,0,0,1,1);
         add_v(1,1,1, 2'd0,0,0,0,0);
         add_v(1,1,0, 2'd0,0,0,1,1);
         add_v(1,1,1, 2'd0,0,0,0,0);
      end

      repeat (2) @(posedge clk);
      #1;
      check("reset_state", obs(), 6'b0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < vq.size(); i++) begin
         step(vq[i].s, vq[i].d, vq[i].c);
         check($sformatf("vec%0d", i), obs(), vq[i].exp);
      end

      // Held start key must not repeat.
      do_reset(1,1,1);
      step(1,1,1);
      step(0,1,1);
      check("hold_first_press", obs(), {2'd1,1'b1,1'b0,1'b0,1'b1});
      n_evt = 0;
      for (int i = 0; i < 1000; i++) begin
         step(0,1,1);
         if (event_pulse || clear_pulse || state != 2'd1) n_evt++;
      end
      check("hold_no_repeat", n_evt, 0);

      // Start held low across reset release.
      do_reset(0,1,1);
      n_evt = 0;
      for (int i = 0; i < 3; i++) begin
         step(0,1,1);
         if (obs() != 6'b0) n_evt++;
      end
      check("held_thru_reset", n_evt, 0);
      step(1,1,1);
      check("held_release", obs(), 6'b0);
      step(0,1,1);
      check("held_repress", obs(), {2'd1,1'b1,1'b0,1'b0,1'b1});

      // Async reset while frozen.
      step(1,1,1);
      step(1,0,1);
      check("enter_freeze", obs(), {2'd3,1'b1,1'b1,1'b0,1'b1});
      @(negedge clk);
      #2 reset = 1'b1;
      #1 check("async_reset_freeze", obs(), 6'b0);
      @(negedge clk);
      reset = 1'b0;
      ks = 1'b1; kd = 1'b1;

      if (LP) begin
         step(1,1,1);
         step(0,1,1);
         step(1,1,1);
         n_evt = 0;
         for (int i = 0; i < 7; i++) begin
            step(1,1,0);
            if (clear_pulse) n_evt++;
         end
         check("lp_short_press", n_evt, 0);
         check("lp_short_state", state, 2'd1);
         step(1,1,1);
         n_evt = 0;
         first_idx = -1;
         for (int i = 1; i <= 20; i++) begin
            step(1,1,0);
            if (clear_pulse) begin
               n_evt++;
               if (first_idx < 0) first_idx = i;
            end
         end
         check("lp_pulse_count", n_evt, 1);
         check("lp_pulse_cycle", first_idx, 8);
         check("lp_final_state", state, 2'd0);
      end else begin
         do_reset(1,1,0);
         step(1,1,0);
         check("clear_held_thru_reset", obs(), 6'b0);
         step(1,1,1);
         step(1,1,0);
         check("clear_after_release", obs(), {2'd0,1'b0,1'b0,1'b1,1'b1});
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
